// File: rtl/pipeline_fork.sv
// -----------------------------------------------------------------------------
// pipeline_fork
//
// One-entry registered broadcast stage. A single valid/ready stream is captured
// into one buffer and offered to N consumers in parallel. Each consumer takes
// the word in its own cycle. The buffer is released only after every consumer
// has taken it. This is the mirror image of an N-to-1 valid/ready join.
//
// Parameters
//   N        number of downstream consumers (N >= 1)
//   W        data width in bits
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   i_valid  upstream word valid
//   i_ready  block can accept an upstream word this cycle
//   i_data   upstream word
//   o_valid  per-consumer valid (unpacked [N])
//   o_ready  per-consumer ready (unpacked [N])
//   o_data   buffered word, shared by all consumers
//
// Buffer state
//   full | meaning
//   -----+----------------------------------------------------------
//    0   | buffer empty; o_valid all low; o_ready ignored
//    1   | word held; lanes with done[k]=0 still owe a transfer
// -----------------------------------------------------------------------------
module pipeline_fork #(
   parameter int N = 2,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid [N],
   input  logic         o_ready [N],
   output logic [W-1:0] o_data
);

   logic         full;
   logic [N-1:0] done;
   logic [W-1:0] data_q;

   logic [N-1:0] pend;
   logic [N-1:0] xfer;
   logic         last;
   logic         in_acc;

   // Valid is a pure function of registered state so consumers never see
   // a combinational loop through their own ready.
   always_comb begin
      pend = '0;
      xfer = '0;
      for (int k = 0; k < N; k++) begin
         pend[k] = full & ~done[k];
         xfer[k] = pend[k] & o_ready[k];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_valid
      assign o_valid[k] = pend[k];
   end

   // The word is freed in the cycle the final outstanding lane transfers;
   // letting that propagate to i_ready keeps throughput at one word/cycle.
   assign last    = full & (&(done | xfer));
   assign i_ready = ~full | last;
   assign in_acc  = i_valid & i_ready;
   assign o_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 1'b0;
         done   <= '0;
         data_q <= '0;
      end else if (in_acc) begin
         // Covers both an empty buffer and one being freed this very cycle.
         full   <= 1'b1;
         done   <= '0;
         data_q <= i_data;
      end else if (last) begin
         // data_q is left as is; o_valid is low so its value is don't-care.
         full   <= 1'b0;
         done   <= '0;
      end else begin
         done   <= done | xfer;
      end
   end

endmodule

// File: tb/tb_pipeline_fork.sv
module tb_pipeline_fork;
   localparam int N = 3;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         i_ready;
   logic [W-1:0] i_data;
   logic         o_valid [N];
   logic         o_ready [N];
   logic [W-1:0] o_data;

   logic [N-1:0] rdy;
   logic [N-1:0] ov;

   pipeline_fork #(.N(N), .W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         o_ready[k] = rdy[k];
         ov[k]      = o_valid[k];
      end
   end

   // Reference model: "is a word held", "which word", "which lanes are still
   // owed it", plus a per-lane queue of words each lane must receive in order.
   bit           m_hold;
   logic [W-1:0] m_word;
   logic [N-1:0] m_owed;
   logic [W-1:0] lane_q [N][$];
   int           rcv_cnt [N];
   int           n_chk = 0;
   int           n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit m_ready();
      return !m_hold || ((m_owed & ~rdy) == '0);
   endfunction

   task automatic model_reset();
      m_hold = 1'b0;
      m_word = '0;
      m_owed = '0;
      for (int k = 0; k < N; k++) lane_q[k].delete();
   endtask

   // Called at a negedge with inputs already driven; returns at next negedge.
   task automatic step();
      bit acc;
      #1;
      chk("o_valid", 32'(ov), 32'(m_owed));
      chk("i_ready", 32'(i_ready), 32'(m_ready()));
      chk("o_data", 32'(o_data), 32'(m_word));
      for (int k = 0; k < N; k++) begin
         if (ov[k] && rdy[k]) begin
            if (lane_q[k].size() == 0) chk($sformatf("lane%0d_extra", k), 32'd1, 32'd0);
            else chk($sformatf("lane%0d_data", k), 32'(o_data), 32'(lane_q[k].pop_front()));
            rcv_cnt[k]++;
         end
      end
      acc = i_valid && m_ready();
      @(posedge clk);
      if (m_hold) begin
         m_owed = m_owed & ~rdy;
         if (m_owed == '0) m_hold = 1'b0;
      end
      if (acc) begin
         m_hold = 1'b1;
         m_word = i_data;
         m_owed = '1;
         for (int k = 0; k < N; k++) lane_q[k].push_back(i_data);
      end
      @(negedge clk);
   endtask

   int base [N];

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      rdy     = '0;
      for (int k = 0; k < N; k++) rcv_cnt[k] = 0;
      model_reset();
      #1;
      chk("rst_o_valid", 32'(ov), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_i_ready", 32'(i_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single word, all lanes ready
      i_valid = 1'b1; i_data = 8'hA5; rdy = 3'b111;
      step();
      i_valid = 1'b0;
      #1;
      chk("t1_ov", 32'(ov), 32'h7);
      chk("t1_data", 32'(o_data), 32'hA5);
      step();
      #1;
      chk("t1_ov_after", 32'(ov), 32'h0);
      chk("t1_ready_after", 32'(i_ready), 32'd1);
      step();

      // staggered acceptance
      i_valid = 1'b1; i_data = 8'h3C; rdy = 3'b000;
      step();
      i_valid = 1'b0; rdy = 3'b100;
      #1; chk("t2_ov_c1", 32'(ov), 32'h7); chk("t2_rdy_c1", 32'(i_ready), 32'd0);
      step();
      rdy = 3'b010;
      #1; chk("t2_ov_c2", 32'(ov), 32'h3); chk("t2_rdy_c2", 32'(i_ready), 32'd0);
      step();
      rdy = 3'b001;
      #1; chk("t2_ov_c3", 32'(ov), 32'h1); chk("t2_rdy_c3", 32'(i_ready), 32'd1);
      step();
      #1; chk("t2_ov_end", 32'(ov), 32'h0);
      step();

      // back-to-back stream
      for (int k = 0; k < N; k++) base[k] = rcv_cnt[k];
      rdy = 3'b111;
      for (int i = 1; i <= 16; i++) begin
         i_valid = 1'b1; i_data = 8'(i);
         step();
      end
      i_valid = 1'b0;
      step();
      for (int k = 0; k < N; k++)
         chk($sformatf("t3_lane%0d_count", k), 32'(rcv_cnt[k] - base[k]), 32'd16);

      // stalled lane blocks the next word
      i_valid = 1'b1; i_data = 8'h77; rdy = 3'b000;
      step();
      i_data = 8'h88; rdy = 3'b101;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t4_ready_stall", 32'(i_ready), 32'd0);
         chk("t4_data_hold", 32'(o_data), 32'h77);
         step();
      end
      rdy = 3'b010;
      #1; chk("t4_ready_free", 32'(i_ready), 32'd1);
      step();
      i_valid = 1'b0; rdy = 3'b111;
      #1; chk("t4_next_data", 32'(o_data), 32'h88); chk("t4_next_ov", 32'(ov), 32'h7);
      step();

      // done lane ignores further ready
      i_valid = 1'b1; i_data = 8'h99; rdy = 3'b000;
      step();
      i_valid = 1'b0; rdy = 3'b001;
      step();
      for (int c = 0; c < 4; c++) begin
         rdy = {2'b00, 1'(c % 2 == 0)};
         #1; chk("t5_ov0_low", 32'(ov[0]), 32'd0);
         step();
      end
      rdy = 3'b110;
      step();

      // asynchronous reset mid-word
      i_valid = 1'b1; i_data = 8'h5A; rdy = 3'b000;
      step();
      i_valid = 1'b0; rdy = 3'b001;
      step();
      rdy = 3'b000;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ov", 32'(ov), 32'h0);
      chk("t6_rst_data", 32'(o_data), 32'h0);
      chk("t6_rst_ready", 32'(i_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      i_valid = 1'b1; i_data = 8'h5B; rdy = 3'b111;
      step();
      i_valid = 1'b0;
      #1; chk("t6_ov_after", 32'(ov), 32'h7); chk("t6_data_after", 32'(o_data), 32'h5B);
      step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_data  = 8'($urandom);
         rdy     = 3'($urandom);
         step();
      end
      i_valid = 1'b0; rdy = 3'b111;
      step();
      step();
      for (int k = 0; k < N; k++)
         chk($sformatf("lane%0d_drained", k), 32'(lane_q[k].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_fork.md
Name: pipeline_fork

Overview:
- One-entry registered broadcast stage. It takes one valid/ready/data stream and delivers the same word to N consumers.
- Each consumer may accept the word in a different cycle.
- The block frees its buffer only after every consumer has taken the word.
- It is the mirror of the N-to-1 valid/ready join. It sits upstream of parallel datapath units (e.g. Montgomery multiplier lanes) that each need a copy of an operand.

Parameters:
- N, 2, number of downstream consumers (N >= 1).
- W, 32, data width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- i_ready  output  1  block can accept upstream word this cycle.
- i_data  input  W  upstream word.
- o_valid  output  N (unpacked [N])  per-consumer valid.
- o_ready  input  N (unpacked [N])  per-consumer ready.
- o_data  output  W  buffered word, shared by all consumers.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- State: full (1 bit), done[N] (per-consumer accepted flag), data register (W bits).
- Reset:
  - full=0, done=all 0, data=0.
  - Outputs during and after reset: o_valid all 0, o_data=0, i_ready=1.
- Output valid: o_valid[k] = full & ~done[k]. It is registered-state only and never depends on o_ready or i_valid.
- Consumer transfer: xfer[k] = o_valid[k] & o_ready[k].
- Last transfer: last = full & AND over k of (done[k] | xfer[k]).
- Input ready: i_ready = ~full | last. This is the only combinational path, o_ready -> i_ready. It gives full throughput of 1 word/cycle when all consumers are ready.
- Input accept: in_acc = i_valid & i_ready.
- Next-state priority:
  1. in_acc: data<=i_data, full<=1, done<=0. This applies whether the buffer was empty or being freed by last in the same cycle.
  2. else if last: full<=0, done<=0.
  3. else: done[k] <= done[k] | xfer[k].
- Latency: word accepted in cycle t appears on o_data with o_valid in cycle t+1.
- o_data holds stable for as long as any o_valid[k] is high.
- Handshake rules:
  - Once o_valid[k] rises, it stays high until xfer[k].
  - Each consumer sees exactly one transfer per word.
  - i_valid deasserting while i_ready=0 has no effect.
- Boundary conditions:
  - All N consumers ready in the first valid cycle: the word is freed that same cycle; a new word is accepted the same cycle if offered.
  - A consumer already done keeps o_valid[k]=0 even if o_ready[k]=1.
  - Empty buffer: xfer is impossible; o_ready is ignored.
  - N=1: the block behaves as a one-entry register slice with bypassed ready.
  - Reset asserted mid-operation: the buffered word is dropped, done is cleared, no output transfer completes. The first i_valid after release is accepted.

Test Plan:
- N=3, W=8; reset, then i_data=0xA5 with i_valid=1 for one cycle and o_ready all 1 -> cycle+1: o_valid=111, o_data=0xA5; cycle+2: o_valid=000 and i_ready=1.
- Word 0x3C; o_ready=100 in cycle 1, 010 in cycle 2, 001 in cycle 3 -> o_valid goes 111, 011, 001, 000. Each lane has exactly one transfer. i_ready=0 until cycle 3, when it is 1 combinationally.
- Back-to-back stream 0x01..0x10 with o_ready all 1 -> 16 words in 17 cycles. Every lane receives 0x01..0x10 in order; no bubbles.
- Word 0x77 pending with lane 1 stalled (o_ready[1]=0 for 5 cycles) and i_valid=1 with i_data=0x88 -> i_ready=0 and o_data=0x77 held stable. When lane 1 accepts, 0x88 is loaded the same cycle and appears next cycle.
- Lane 0 done, lanes 1-2 pending; o_ready[0] toggled -> no duplicate transfer on lane 0; o_valid[0]=0 throughout.
- rst_n pulsed low asynchronously with 0x5A half-delivered (done=001) -> o_valid=000 immediately and o_data=0. After release, i_data=0x5B is accepted and delivered to all 3 lanes.
